// File: rtl/err_code_decoder_pkg.sv
// Shared types and constants for the error-code decoder and its bench model.
// Holds the sequencer state encoding, error-code bounds and the code decode helper.
// No logic of its own; imported by every file of the block.
package err_code_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SOFTSTART = 2'b01,
    RUN       = 2'b10
  } state_t;

  // Largest legal positive and most negative legal codes (two's complement).
  localparam logic [3:0] CODE_POS_MAX = 4'b0100;
  localparam logic [3:0] CODE_NEG_MAX = 4'b1100;

  typedef struct packed {
    logic signed [3:0] val;
    logic              illegal;
  } dec_t;

  // Legal codes are -4..+4; anything in 0101..1011 decodes to zero and is flagged.
  function automatic dec_t decode_code(input logic [3:0] code);
    dec_t d;
    d.val     = 4'sd0;
    d.illegal = 1'b0;
    if (code <= CODE_POS_MAX || code >= CODE_NEG_MAX) begin
      d.val = signed'(code);
    end else begin
      d.illegal = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/err_code_decoder_if.sv
// Bus between the window encoder / controller side and the error-code decoder.
// master drives enable, code and configuration; slave returns the duty command and status.
// Purely wires; no storage.
interface err_code_decoder_if
  import err_code_decoder_pkg::*;
#(
  parameter int DUTY_W = 10,
  parameter int DIV_W  = 8
);
  logic              en;
  logic [3:0]        err_code;
  logic [DIV_W-1:0]  sample_div;
  logic [1:0]        gain_sh;
  logic [DUTY_W-1:0] duty;
  logic              duty_vld;
  state_t            state;
  logic              sat_hi;
  logic              sat_lo;
  logic              bad_code;

  modport master (
    output en, err_code, sample_div, gain_sh,
    input  duty, duty_vld, state, sat_hi, sat_lo, bad_code
  );

  modport slave (
    input  en, err_code, sample_div, gain_sh,
    output duty, duty_vld, state, sat_hi, sat_lo, bad_code
  );
endinterface

// File: rtl/err_rate_div.sv
// Update-rate divider: raises tick once every sample_div+1 enabled cycles.
// tick is combinational from the registered count, so it is valid in the same cycle.
// Disabled means the count is held at zero; a smaller live sample_div ticks at once.
module err_rate_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] sample_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a live drop of sample_div below the count cannot wedge the divider.
  assign tick = en && (cnt >= sample_div);

  // Count enabled cycles, wrap on tick, park at zero while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/err_code_decoder.sv
// Decodes the 4-bit error code, scales it by gain_sh and integrates it into a clamped duty command.
// Code registered on entry; a tick in the next cycle writes duty with duty_vld one edge later.
// No backpressure: duty_vld is a one-cycle strobe the DPWM must accept.
module err_code_decoder
  import err_code_decoder_pkg::*;
#(
  parameter int DUTY_W    = 10,
  parameter int DIV_W     = 8,
  parameter int DUTY_MIN  = 0,
  parameter int DUTY_MAX  = 1000,
  parameter int SS_TARGET = 500,
  parameter int SS_STEP   = 1
) (
  input logic               clk,
  input logic               rst,
  err_code_decoder_if.slave bus
);

  localparam logic [DUTY_W-1:0]        MIN_D = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0]        MAX_D = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0]        TGT_D = DUTY_W'(SS_TARGET);
  localparam logic [DUTY_W:0]          TGT_X = (DUTY_W+1)'(SS_TARGET);
  localparam logic [DUTY_W:0]          STP_X = (DUTY_W+1)'(SS_STEP);
  localparam logic signed [DUTY_W+1:0] MIN_X = (DUTY_W+2)'(DUTY_MIN);
  localparam logic signed [DUTY_W+1:0] MAX_X = (DUTY_W+2)'(DUTY_MAX);

  logic [3:0]               code_q;
  dec_t                     dec;
  logic signed [6:0]        step;
  logic signed [DUTY_W+1:0] sum_run;
  logic [DUTY_W:0]          sum_ss;
  logic                     div_en;
  logic                     tick;

  // Divider only runs in an active state with enable still high, so en=0 beats a tick.
  assign div_en = (bus.state != IDLE) && bus.en;

  err_rate_div #(.DIV_W(DIV_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .en         (div_en),
    .sample_div (bus.sample_div),
    .tick       (tick)
  );

  // Capture the incoming code every cycle; everything downstream works from this copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= 4'b0000;
    end else begin
      code_q <= bus.err_code;
    end
  end

  // Sign-extend to 7 bits before shifting so -4<<3 = -32 keeps its sign.
  assign dec     = decode_code(code_q);
  assign step    = {{3{dec.val[3]}}, dec.val} <<< bus.gain_sh;
  assign sum_run = $signed({2'b00, bus.duty}) + $signed({{(DUTY_W-5){step[6]}}, step});
  assign sum_ss  = {1'b0, bus.duty} + STP_X;

  // Sequencer and integrator: all outputs registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.state    <= IDLE;
      bus.duty     <= MIN_D;
      bus.duty_vld <= 1'b0;
      bus.sat_hi   <= 1'b0;
      bus.sat_lo   <= 1'b0;
      bus.bad_code <= 1'b0;
    end else begin
      bus.bad_code <= dec.illegal;
      bus.duty_vld <= 1'b0;
      if (!bus.en) begin
        bus.state  <= IDLE;
        bus.duty   <= MIN_D;
        bus.sat_hi <= 1'b0;
        bus.sat_lo <= 1'b0;
      end else begin
        case (bus.state)
          IDLE: begin
            bus.state <= SOFTSTART;
            bus.duty  <= MIN_D;
          end
          SOFTSTART: begin
            if (tick) begin
              bus.duty_vld <= 1'b1;
              if (sum_ss >= TGT_X) begin
                bus.duty  <= TGT_D;
                bus.state <= RUN;
              end else begin
                bus.duty <= sum_ss[DUTY_W-1:0];
              end
            end
          end
          RUN: begin
            if (tick) begin
              bus.duty_vld <= 1'b1;
              if (sum_run > MAX_X) begin
                bus.duty   <= MAX_D;
                bus.sat_hi <= 1'b1;
                bus.sat_lo <= 1'b0;
              end else if (sum_run < MIN_X) begin
                bus.duty   <= MIN_D;
                bus.sat_hi <= 1'b0;
                bus.sat_lo <= 1'b1;
              end else begin
                bus.duty   <= sum_run[DUTY_W-1:0];
                bus.sat_hi <= 1'b0;
                bus.sat_lo <= 1'b0;
              end
            end
          end
          default: begin
            bus.state <= IDLE;
            bus.duty  <= MIN_D;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_err_code_decoder.sv
// Directed bench for err_code_decoder with a cycle-accurate scoreboard.
// Each driven cycle pushes the expected outputs; a monitor pops and compares after the edge.
// Directed constant checks cover the specific duty values of each scenario.
module tb_err_code_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  err_code_decoder_if #(.DUTY_W(10), .DIV_W(8)) bus ();

  err_code_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       vld;
    logic [9:0] duty;
    logic [1:0] st;
    logic       hi;
    logic       lo;
    logic       bad;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int         m_st   = 0;
  int         m_duty = 0;
  int         m_cnt  = 0;
  int         m_hi   = 0;
  int         m_lo   = 0;
  logic [3:0] m_code = 4'b0000;
  logic [7:0] cur_sd = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int m_dec(input logic [3:0] c);
    case (c)
      4'd0: return 0;   4'd1: return 1;   4'd2: return 2;   4'd3: return 3;
      4'd4: return 4;   4'd15: return -1; 4'd14: return -2; 4'd13: return -3;
      4'd12: return -4;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_bad(input logic [3:0] c);
    return (c >= 4'd5) && (c <= 4'd11);
  endfunction

  task automatic model_reset();
    m_st = 0; m_duty = 0; m_cnt = 0; m_hi = 0; m_lo = 0; m_code = 4'b0000;
    sb.delete();
  endtask

  // Predict the outputs after the coming clock edge and push them.
  task automatic model(input logic e, input logic [3:0] c, input int g, input int sd);
    exp_t x;
    int   s;
    logic tk;
    tk    = (m_st != 0) && (m_cnt >= sd);
    x.bad = m_bad(m_code);
    x.vld = 1'b0;
    if (!e) begin
      m_st = 0; m_duty = 0; m_hi = 0; m_lo = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_cnt = 0;
    end else if (!tk) begin
      m_cnt++;
    end else begin
      m_cnt = 0;
      x.vld = 1'b1;
      if (m_st == 1) begin
        m_duty += 1;
        if (m_duty >= 500) begin
          m_duty = 500; m_st = 2;
        end
      end else begin
        s = m_duty + m_dec(m_code) * (1 << g);
        if (s > 1000)   begin m_duty = 1000; m_hi = 1; m_lo = 0; end
        else if (s < 0) begin m_duty = 0;    m_hi = 0; m_lo = 1; end
        else            begin m_duty = s;    m_hi = 0; m_lo = 0; end
      end
    end
    m_code = c;
    x.duty = 10'(m_duty);
    x.st   = 2'(m_st);
    x.hi   = (m_hi != 0);
    x.lo   = (m_lo != 0);
    sb.push_back(x);
  endtask

  task automatic drive_now(input logic e, input logic [3:0] c, input logic [1:0] g);
    bus.en = e; bus.err_code = c; bus.gain_sh = g; bus.sample_div = cur_sd;
    model(e, c, int'(g), int'(cur_sd));
  endtask

  task automatic step(input logic e, input logic [3:0] c, input logic [1:0] g);
    @(negedge clk);
    drive_now(e, c, g);
  endtask

  // Present a code for one cycle, then zero; the second edge applies the code.
  task automatic pulse(input logic [3:0] c, input logic [1:0] g);
    step(1'b1, c, g);
    step(1'b1, 4'b0000, g);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: one expected entry per driven cycle.
  initial begin : mon
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("sb_vld",   32'(bus.duty_vld), 32'(x.vld));
        chk("sb_duty",  32'(bus.duty),     32'(x.duty));
        chk("sb_state", 32'(bus.state),    32'(x.st));
        chk("sb_sathi", 32'(bus.sat_hi),   32'(x.hi));
        chk("sb_satlo", 32'(bus.sat_lo),   32'(x.lo));
        chk("sb_bad",   32'(bus.bad_code), 32'(x.bad));
      end
    end
  end

  initial begin : main
    bus.en = 1'b0; bus.err_code = 4'b0000; bus.gain_sh = 2'd0; bus.sample_div = 8'd0;
    #3;
    chk("rst_duty",  32'(bus.duty),     32'd0);
    chk("rst_vld",   32'(bus.duty_vld), 32'd0);
    chk("rst_state", 32'(bus.state),    32'd0);
    chk("rst_sat",   32'({bus.sat_hi, bus.sat_lo}), 32'd0);
    chk("rst_bad",   32'(bus.bad_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Soft-start ramp at one tick per cycle.
    cur_sd = 8'd0;
    step(1'b1, 4'b0000, 2'd0);
    for (int i = 1; i <= 500; i++) begin
      step(1'b1, 4'b0000, 2'd0);
      if (i == 1) begin
        after_edge();
        chk("ss_first_duty", 32'(bus.duty), 32'd1);
      end
    end
    after_edge();
    chk("ss_end_duty",  32'(bus.duty),  32'd500);
    chk("ss_end_state", 32'(bus.state), 32'd2);

    // RUN integration, +3 every 4th cycle.
    cur_sd = 8'd3;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, (i == 12) ? 4'b0000 : 4'b0011, 2'd0);
      if (i % 4 == 0) begin
        after_edge();
        chk("run_duty", 32'(bus.duty), 32'(500 + 3 * (i / 4)));
        chk("run_vld",  32'(bus.duty_vld), 32'd1);
      end else if (i == 5) begin
        after_edge();
        chk("run_novld", 32'(bus.duty_vld), 32'd0);
      end
    end

    // Back to 500, then gain 8 on -4.
    cur_sd = 8'd0;
    pulse(4'b1100, 2'd1);
    pulse(4'b1111, 2'd0);
    after_edge();
    chk("back_500", 32'(bus.duty), 32'd500);
    pulse(4'b1100, 2'd3);
    after_edge();
    chk("gain_neg", 32'(bus.duty), 32'd468);

    // Climb to 995 then saturate high.
    for (int i = 0; i < 16; i++) pulse(4'b0100, 2'd3);
    pulse(4'b0100, 2'd1);
    pulse(4'b0100, 2'd0);
    pulse(4'b0011, 2'd0);
    after_edge();
    chk("at_995", 32'(bus.duty), 32'd995);
    pulse(4'b0100, 2'd1);
    after_edge();
    chk("sathi_duty", 32'(bus.duty),   32'd1000);
    chk("sathi_flag", 32'(bus.sat_hi), 32'd1);
    pulse(4'b1111, 2'd0);
    after_edge();
    chk("unsat_duty", 32'(bus.duty),   32'd999);
    chk("unsat_flag", 32'(bus.sat_hi), 32'd0);

    // Descend to 3 then saturate low.
    for (int i = 0; i < 31; i++) pulse(4'b1100, 2'd3);
    pulse(4'b1100, 2'd0);
    after_edge();
    chk("at_3", 32'(bus.duty), 32'd3);
    pulse(4'b1100, 2'd0);
    after_edge();
    chk("satlo_duty", 32'(bus.duty),   32'd0);
    chk("satlo_flag", 32'(bus.sat_lo), 32'd1);

    // Illegal code: zero step, still a write.
    pulse(4'b0110, 2'd0);
    after_edge();
    chk("ill_bad",  32'(bus.bad_code), 32'd1);
    chk("ill_vld",  32'(bus.duty_vld), 32'd1);
    chk("ill_duty", 32'(bus.duty),     32'd0);

    // Disable on a tick cycle.
    pulse(4'b0100, 2'd3);
    after_edge();
    chk("pre_dis_duty", 32'(bus.duty), 32'd32);
    step(1'b0, 4'b0000, 2'd0);
    after_edge();
    chk("dis_vld",   32'(bus.duty_vld), 32'd0);
    chk("dis_duty",  32'(bus.duty),     32'd0);
    chk("dis_state", 32'(bus.state),    32'd0);

    // Re-enable restarts soft-start from zero.
    step(1'b1, 4'b0000, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 2'd0);
    after_edge();
    chk("restart_duty",  32'(bus.duty),  32'd3);
    chk("restart_state", 32'(bus.state), 32'd1);
    for (int i = 0; i < 600 && m_st != 2; i++) step(1'b1, 4'b0000, 2'd0);
    after_edge();
    chk("ramp2_state", 32'(bus.state), 32'd2);

    // Live sample_div change mid-count.
    cur_sd = 8'd7;
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0001, 2'd0);
    cur_sd = 8'd1;
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, 2'd0);

    // Async reset mid-cycle in RUN.
    cur_sd = 8'd0;
    step(1'b1, 4'b0000, 2'd0);
    pulse(4'b0100, 2'd3);
    after_edge();
    chk("pre_rst_state", 32'(bus.state), 32'd2);
    rst = 1'b1;
    #1;
    chk("arst_duty",  32'(bus.duty),     32'd0);
    chk("arst_state", 32'(bus.state),    32'd0);
    chk("arst_vld",   32'(bus.duty_vld), 32'd0);
    chk("arst_sat",   32'({bus.sat_hi, bus.sat_lo}), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_now(1'b1, 4'b0000, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 2'd0);
    after_edge();
    chk("post_rst_duty", 32'(bus.duty), 32'd3);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/err_code_decoder.md
Name: err_code_decoder

Overview:
- Receive side of the 4-bit error-code interface driven by the ADC-window encoder.
- Decodes the signed error code, scales it, and integrates it into a clamped duty command for the DPWM.
- Adds an IDLE/SOFTSTART/RUN sequencer and a programmable update-rate divider.
- Sits between the window encoder and the multi-phase DPWM / phase distributor.

Parameters:
DUTY_W, 10, width of duty command (unsigned)
DIV_W, 8, width of update-rate divider
DUTY_MIN, 0, lower duty clamp and IDLE value
DUTY_MAX, 1000, upper duty clamp (must be < 2^DUTY_W)
SS_TARGET, 500, duty level at which soft-start hands over to RUN
SS_STEP, 1, duty increment per tick during soft-start

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  converter enable; level-sensitive
err_code  in  4  two's-complement error code from encoder; positive means output low, so duty increases
sample_div  in  DIV_W  update period minus 1, in clk cycles
gain_sh  in  2  left-shift applied to decoded error (gain 1/2/4/8)
duty  out  DUTY_W  duty command to DPWM
duty_vld  out  1  one-cycle pulse when duty is written
state  out  2  00 IDLE, 01 SOFTSTART, 10 RUN
sat_hi  out  1  last update clamped at DUTY_MAX
sat_lo  out  1  last update clamped at DUTY_MIN
bad_code  out  1  one-cycle pulse, illegal code received

Behaviour:
- Clock and reset: rst is asynchronous, active-high; clk is the clock.
- Reset values: duty=DUTY_MIN, duty_vld=0, state=IDLE, sat_hi=0, sat_lo=0, bad_code=0, divider counter=0, code register=0.
- Input register: err_code is registered every clk edge and feeds all downstream logic.
- Decode of the registered code:
  - 0000..0100 -> 0..+4
  - 1111..1100 -> -1..-4
  - 0101..1011 are illegal: decode as 0, and bad_code pulses on the cycle after the register captures the code.
- Step: decoded value << gain_sh, range -32..+32. Sign-extend before the shift.
- Divider:
  - Counter increments every cycle while state != IDLE.
  - When counter >= sample_div, tick=1 and counter returns to 0.
  - sample_div=0 gives a tick every cycle.
  - A live change of sample_div takes effect immediately through the >= compare; no stuck count.
  - In IDLE the counter is held at 0.
- Latency: err_code present before edge k is captured at k. If tick is true in the following cycle, duty reflects the code at edge k+1, with duty_vld=1 in that same cycle.
- IDLE:
  - duty=DUTY_MIN.
  - en=1 moves to SOFTSTART on the next edge.
- SOFTSTART:
  - On each tick, duty += SS_STEP and duty_vld pulses.
  - When the new duty >= SS_TARGET, duty=SS_TARGET and the next state is RUN.
  - err_code is ignored; bad_code still reports illegal codes.
- RUN:
  - On each tick, compute duty+step in DUTY_W+2 signed arithmetic, clamp to [DUTY_MIN, DUTY_MAX], write duty, pulse duty_vld.
  - sat_hi and sat_lo update on every RUN tick: 1 if that tick clamped at that bound, otherwise 0. They hold between ticks.
- en=0 in any state:
  - Next edge: state=IDLE, duty=DUTY_MIN, sat flags=0, no duty_vld.
  - en=0 takes priority over a simultaneous tick.
- en re-assert during the IDLE cycle restarts soft-start from DUTY_MIN.
- Async rst mid-operation returns all outputs to their reset values immediately. The first edge after release is evaluated as IDLE.
- Step = 0 at a tick still writes duty and pulses duty_vld.

Decomposition:
- Shared package:
  - state encoding constants IDLE/SOFTSTART/RUN
  - error-code constants CODE_POS_MAX=4'b0100, CODE_NEG_MAX=4'b1100
  - a decode function (4-bit code -> signed 4-bit value + illegal flag) for reuse by the bench model
- Natural sub-module: err_rate_div, the divider counter with its enable and tick output. The sequencer and integrator stay in the top module.

Test Plan:
- Reset/start: rst pulse, en=1, sample_div=0, SS_STEP=1 -> duty ramps 1,2,… with duty_vld each cycle; reaches 500 after 500 ticks; state=RUN next cycle.
- RUN integration: duty=500, gain_sh=0, err_code=0011 held, sample_div=3 -> duty 503, 506, 509 on every 4th cycle; duty_vld only on those cycles; first update 2 edges after the code is applied.
- Gain/negative: duty=500, gain_sh=3, err_code=1100 -> duty 468 on the next tick.
- Saturation:
  - duty=995, code=0100, gain_sh=1 -> duty=1000, sat_hi=1.
  - Then code=1111, gain_sh=0 -> duty=999, sat_hi=0.
  - Symmetric case at duty=3, code=1100 -> duty=0, sat_lo=1.
- Illegal code: err_code=0110 in RUN -> bad_code one-cycle pulse, step treated as 0, duty unchanged but duty_vld pulses on the tick.
- Disable/reset races:
  - en falls on the same cycle as a tick -> no duty_vld, duty=0, state=IDLE.
  - Async rst asserted mid-cycle in RUN -> duty=0 before the next edge.
